avalon_mm_arbiter: RTL and testbench
====================================

Name: avalon_mm_arbiter

Overview:
Two-requester arbiter/sequencer in front of the mm_bridge_s Avalon-MM slave of the system interconnect (SDRAM, HEX, LEDs, keys, switches). It shares the bridge between the RISC-V core's instruction-fetch port (read-only) and data port (read/write). Arbitration is round-robin, with one outstanding transaction at a time. A timeout recovers from a hung slave.

Parameters:
ADDR_W, 28, address width (matches bridge address)
DATA_W, 32, data width; byteenable width = DATA_W/8
TIMEOUT, 255, max cycles in ISSUE+WAIT_RD before abort; 0 disables timeout

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
i_req  in  1  instruction read request, held until i_ack
i_addr  in  ADDR_W  instruction byte address
i_ack  out  1  one-cycle completion pulse
i_rdata  out  DATA_W  read data, valid with i_ack
i_err  out  1  timeout abort flag, valid with i_ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  write data
d_be  in  DATA_W/8  byte enables
d_ack  out  1  one-cycle completion pulse
d_rdata  out  DATA_W  read data, valid with d_ack
d_err  out  1  timeout abort flag, valid with d_ack
m_address  out  ADDR_W  to bridge address
m_read  out  1  to bridge read
m_write  out  1  to bridge write
m_writedata  out  DATA_W  to bridge writedata
m_byteenable  out  DATA_W/8  to bridge byteenable
m_burstcount  out  1  constant 1
m_debugaccess  out  1  constant 0
m_waitrequest  in  1  from bridge
m_readdata  in  DATA_W  from bridge
m_readdatavalid  in  1  from bridge

Behaviour:
- Reset (async assert, sync release): state=IDLE; rr_last=D (instruction port wins first tie); all outputs 0 except m_burstcount=1; timeout counter=0.
- All m_* and *_ack/*_rdata/*_err outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE:
  - Only i_req → grant I. Only d_req → grant D. Both → grant the port that is not rr_last.
  - On grant: latch owner, addr, we (forced 0 for I), wdata, be (all ones for I). Set rr_last=owner. Go to ISSUE.
- ISSUE: m_read=!we, m_write=we, address/data/be driven from latches and held stable while m_waitrequest=1.
  - When m_waitrequest=0: write → DONE; read → WAIT_RD. m_read/m_write deassert next cycle.
- WAIT_RD: m_read=0. On m_readdatavalid=1, latch m_readdata into the owner's rdata and go to DONE.
- DONE: owner's ack=1 for exactly one cycle; err=0 (or 1 after abort). Then go to IDLE. Non-owner ack stays 0.
- Requester contract: deassert req in the cycle after ack. IDLE re-samples req one cycle after DONE, so the same request is never re-granted.
- Write latency: grant at cycle 0 (IDLE), m_write at cycle 1, ack at cycle k+1 where k is the first cycle with m_waitrequest=0.
- Read latency: ack one cycle after m_readdatavalid. Best case is 3 cycles from IDLE.
- m_readdatavalid in ISSUE, IDLE or DONE is ignored. The slave must return data at least one cycle after accept.
- rdata for the owner holds its last value until the next read completion for that port. On a write ack, rdata is unchanged.
- Timeout (TIMEOUT>0):
  - Counter clears on entering ISSUE and increments each cycle in ISSUE/WAIT_RD.
  - On reaching TIMEOUT: drop m_read/m_write, go to DONE with err=1 and owner rdata=0.
  - A late m_readdatavalid after an abort is ignored.
- A request is never preempted. A req raised during another port's transaction waits and is granted first on the next IDLE if it is still asserted.
- reset_reset_n asserted mid-transaction: immediate return to reset values with no ack. The bridge sees m_read/m_write drop asynchronously.

Test Plan:
- Single I read of 0x0000100, m_waitrequest=0, readdatavalid 2 cycles after accept with 0xCAFEF00D → m_read high 1 cycle, i_ack at cycle 4 with i_rdata=0xCAFEF00D, i_err=0.
- D write to 0x0000200, wdata 0x12345678, be=0xC, waitrequest held 3 cycles → m_address/m_writedata/m_byteenable stable 4 cycles, d_ack 1 cycle after accept, d_rdata unchanged.
- i_req and d_req asserted together from reset, each re-requesting after ack → grants alternate I,D,I,D. Four transactions, no ack overlap.
- Read with readdatavalid never returned, TIMEOUT=8 → m_read drops, ack 1 cycle later with err=1 and rdata=0. A readdatavalid injected afterwards produces no ack.
- Reset asserted while in WAIT_RD → all outputs 0 (m_burstcount=1) immediately. After release, the next i_req is granted to I before D (tie).
- Spurious m_readdatavalid in IDLE, then D read → no ack from the spurious beat. The D read completes with the correct data.

Source files
------------

// File: rtl/avalon_mm_arbiter.sv
// Round-robin two-port sequencer sharing one Avalon-MM bridge between instruction fetch and data.
// One outstanding transaction at a time, all outputs registered, optional hung-slave timeout.
module avalon_mm_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,

  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,

  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_burstcount,
  output logic                m_debugaccess,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]       state;
  logic             owner;
  logic             rr_last;
  logic             lat_we;
  logic [CNT_W-1:0] cnt;

  logic grant_d;
  logic timeout_hit;
  logic accept;
  logic data_beat;
  logic abort;
  logic finish;

  // On a tie the port that did not win last time gets the bridge.
  assign grant_d     = d_req && (!i_req || (rr_last == OWN_I));
  assign timeout_hit = (TIMEOUT > 0) && (cnt == TO_LAST);

  assign accept    = (state == S_ISSUE) && !m_waitrequest;
  assign data_beat = (state == S_WAIT_RD) && m_readdatavalid;
  // A slave response arriving on the last allowed cycle still wins over the abort.
  assign abort     = timeout_hit &&
                     (((state == S_ISSUE) && m_waitrequest) ||
                      ((state == S_WAIT_RD) && !m_readdatavalid));
  assign finish    = (accept && lat_we) || data_beat || abort;

  assign m_burstcount  = 1'b1;
  assign m_debugaccess = 1'b0;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= S_IDLE;
      owner        <= OWN_I;
      rr_last      <= OWN_D;
      lat_we       <= 1'b0;
      cnt          <= '0;
      m_address    <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      m_byteenable <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req || d_req) begin
            owner        <= grant_d;
            rr_last      <= grant_d;
            lat_we       <= grant_d && d_we;
            m_address    <= grant_d ? d_addr : i_addr;
            m_writedata  <= grant_d ? d_wdata : '0;
            m_byteenable <= grant_d ? d_be : '1;
            m_read       <= !(grant_d && d_we);
            m_write      <= grant_d && d_we;
            cnt          <= '0;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt <= cnt + 1'b1;
          if (accept) begin
            m_read  <= 1'b0;
            m_write <= 1'b0;
            state   <= lat_we ? S_DONE : S_WAIT_RD;
          end else if (abort) begin
            m_read  <= 1'b0;
            m_write <= 1'b0;
            state   <= S_DONE;
          end
        end
        S_WAIT_RD: begin
          cnt <= cnt + 1'b1;
          if (data_beat || abort) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Completion side: ack/err pulse with the DONE state; rdata only moves on a read beat or an abort.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      i_ack   <= 1'b0;
      i_err   <= 1'b0;
      i_rdata <= '0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;
      d_rdata <= '0;
    end else begin
      i_ack <= 1'b0;
      i_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      if (finish) begin
        if (owner == OWN_D) begin
          d_ack <= 1'b1;
          d_err <= abort;
        end else begin
          i_ack <= 1'b1;
          i_err <= abort;
        end
      end
      if (data_beat) begin
        if (owner == OWN_D) d_rdata <= m_readdata;
        else                i_rdata <= m_readdata;
      end else if (abort) begin
        if (owner == OWN_D) d_rdata <= '0;
        else                i_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Directed bench for avalon_mm_arbiter: single read, held write, round-robin alternation,
// timeout abort, reset mid-transaction and a spurious readdatavalid beat.
module tb_avalon_mm_arbiter;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;

  logic        i_req;
  logic [27:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [27:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [27:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_burstcount;
  logic        m_debugaccess;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;

  int total = 0;
  int bad   = 0;

  always #5 clk_clk = ~clk_clk;

  avalon_mm_arbiter #(
    .ADDR_W (28),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .i_ack          (i_ack),
    .i_rdata        (i_rdata),
    .i_err          (i_err),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_be           (d_be),
    .d_ack          (d_ack),
    .d_rdata        (d_rdata),
    .d_err          (d_err),
    .m_address      (m_address),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_writedata    (m_writedata),
    .m_byteenable   (m_byteenable),
    .m_burstcount   (m_burstcount),
    .m_debugaccess  (m_debugaccess),
    .m_waitrequest  (m_waitrequest),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ir, input logic [27:0] ia, input logic dr, input logic dwe,
                               input logic [27:0] da, input logic [31:0] dwd, input logic [3:0] dbe);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
    d_be    = dbe;
  endtask

  task automatic doReset();
    reset_reset_n = 1'b0;
    applyStimulus(1'b0, 28'h0, 1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
    m_waitrequest   = 1'b0;
    m_readdatavalid = 1'b0;
    m_readdata      = 32'h0;
    tick();
    tick();
    reset_reset_n = 1'b1;
  endtask

  // Zero-wait slave: returns one beat the cycle after it sees m_read accepted.
  task automatic runTxn(input logic [31:0] word, output logic got_i, output logic got_d);
    int   n;
    logic pend;
    n    = 0;
    pend = 1'b0;
    while (!(i_ack || d_ack) && n < 30) begin
      m_readdatavalid = pend;
      m_readdata      = pend ? word : 32'h0;
      pend            = m_read;
      tick();
      n++;
    end
    m_readdatavalid = 1'b0;
    m_readdata      = 32'h0;
    got_i = i_ack;
    got_d = d_ack;
    checkOutput("txn_in_time", 64'(n < 30), 64'd1);
    checkOutput("ack_overlap", 64'(i_ack && d_ack), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic gi;
    logic gd;

    reset_reset_n = 1'b1;
    applyStimulus(1'b0, 28'h0, 1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
    m_waitrequest   = 1'b0;
    m_readdatavalid = 1'b0;
    m_readdata      = 32'h0;
    #1 reset_reset_n = 1'b0;
    #2;
    checkOutput("rst_m_read",     m_read, 0);
    checkOutput("rst_m_write",    m_write, 0);
    checkOutput("rst_m_address",  m_address, 0);
    checkOutput("rst_m_be",       m_byteenable, 0);
    checkOutput("rst_burstcount", m_burstcount, 1);
    checkOutput("rst_debugacc",   m_debugaccess, 0);
    checkOutput("rst_acks",       {i_ack, d_ack, i_err, d_err}, 0);
    checkOutput("rst_rdata",      {i_rdata, d_rdata}, 0);
    tick();
    tick();
    reset_reset_n = 1'b1;

    // Single instruction read, data two cycles after accept.
    applyStimulus(1'b1, 28'h0000100, 1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
    tick();
    checkOutput("t1_m_read_c1",  m_read, 1);
    checkOutput("t1_m_write_c1", m_write, 0);
    checkOutput("t1_address",    m_address, 28'h0000100);
    checkOutput("t1_be",         m_byteenable, 4'hF);
    tick();
    checkOutput("t1_m_read_c2", m_read, 0);
    tick();
    checkOutput("t1_early_ack", i_ack, 0);
    m_readdatavalid = 1'b1;
    m_readdata      = 32'hCAFEF00D;
    tick();
    m_readdatavalid = 1'b0;
    m_readdata      = 32'h0;
    checkOutput("t1_i_ack",  i_ack, 1);
    checkOutput("t1_i_rdata", i_rdata, 32'hCAFEF00D);
    checkOutput("t1_i_err",  i_err, 0);
    checkOutput("t1_d_ack",  d_ack, 0);
    i_req = 1'b0;
    tick();
    checkOutput("t1_ack_pulse", i_ack, 0);

    // Spurious beat in IDLE, then a data read.
    m_readdatavalid = 1'b1;
    m_readdata      = 32'hBAD0BAD0;
    tick();
    m_readdatavalid = 1'b0;
    m_readdata      = 32'h0;
    checkOutput("t6_spur_c1", {i_ack, d_ack}, 0);
    tick();
    checkOutput("t6_spur_c2", {i_ack, d_ack}, 0);
    applyStimulus(1'b0, 28'h0, 1'b1, 1'b0, 28'h0000300, 32'hFFFFFFFF, 4'h3);
    tick();
    checkOutput("t6_m_read",  m_read, 1);
    checkOutput("t6_m_write", m_write, 0);
    checkOutput("t6_address", m_address, 28'h0000300);
    checkOutput("t6_be",      m_byteenable, 4'h3);
    tick();
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h5A5A1234;
    tick();
    m_readdatavalid = 1'b0;
    m_readdata      = 32'h0;
    checkOutput("t6_d_ack",   d_ack, 1);
    checkOutput("t6_d_rdata", d_rdata, 32'h5A5A1234);
    checkOutput("t6_d_err",   d_err, 0);
    checkOutput("t6_i_ack",   i_ack, 0);
    checkOutput("t6_i_rdata", i_rdata, 32'hCAFEF00D);
    d_req = 1'b0;
    tick();

    // Data write with waitrequest held for three cycles.
    applyStimulus(1'b0, 28'h0, 1'b1, 1'b1, 28'h0000200, 32'h12345678, 4'hC);
    m_waitrequest = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checkOutput($sformatf("t2_m_write_c%0d", c), m_write, 1);
      checkOutput($sformatf("t2_m_read_c%0d", c),  m_read, 0);
      checkOutput($sformatf("t2_addr_c%0d", c),    m_address, 28'h0000200);
      checkOutput($sformatf("t2_wdata_c%0d", c),   m_writedata, 32'h12345678);
      checkOutput($sformatf("t2_be_c%0d", c),      m_byteenable, 4'hC);
      checkOutput($sformatf("t2_noack_c%0d", c),   d_ack, 0);
      if (c == 4) m_waitrequest = 1'b0;
    end
    tick();
    checkOutput("t2_d_ack",   d_ack, 1);
    checkOutput("t2_m_write", m_write, 0);
    checkOutput("t2_d_rdata", d_rdata, 32'h5A5A1234);
    checkOutput("t2_d_err",   d_err, 0);
    d_req = 1'b0;
    tick();

    // Both ports requesting from reset: grants alternate I, D, I, D.
    doReset();
    applyStimulus(1'b1, 28'h0000010, 1'b1, 1'b0, 28'h0000020, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      runTxn(32'hA0000000 + 32'(k), gi, gd);
      checkOutput($sformatf("t3_owner_%0d", k), {gi, gd}, (k % 2 == 0) ? 2'b10 : 2'b01);
      checkOutput($sformatf("t3_rdata_%0d", k), gi ? i_rdata : d_rdata, 32'hA0000000 + 32'(k));
      if (k == 3) begin
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
      end else begin
        if (gi) i_req = 1'b0;
        if (gd) d_req = 1'b0;
        tick();
        i_req = 1'b1;
        d_req = 1'b1;
      end
    end

    // Read that never returns data: abort after 8 cycles in ISSUE/WAIT_RD.
    applyStimulus(1'b1, 28'h0000400, 1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
    tick();
    checkOutput("t4_m_read_c1", m_read, 1);
    for (int c = 2; c <= 8; c++) begin
      tick();
      checkOutput($sformatf("t4_m_read_c%0d", c), m_read, 0);
      checkOutput($sformatf("t4_noack_c%0d", c), i_ack, 0);
    end
    tick();
    checkOutput("t4_i_ack",   i_ack, 1);
    checkOutput("t4_i_err",   i_err, 1);
    checkOutput("t4_i_rdata", i_rdata, 32'h0);
    i_req = 1'b0;
    tick();
    m_readdatavalid = 1'b1;
    m_readdata      = 32'hDEADBEEF;
    checkOutput("t4_ack_pulse", i_ack, 0);
    tick();
    m_readdatavalid = 1'b0;
    m_readdata      = 32'h0;
    checkOutput("t4_late_beat", {i_ack, d_ack}, 0);
    tick();
    checkOutput("t4_late_beat2", {i_ack, d_ack}, 0);
    checkOutput("t4_rdata_kept", i_rdata, 32'h0);

    // Reset during WAIT_RD, then a tie must go to the instruction port.
    applyStimulus(1'b1, 28'h0000500, 1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
    tick();
    checkOutput("t5_m_read", m_read, 1);
    tick();
    checkOutput("t5_addr_pre", m_address, 28'h0000500);
    #2 reset_reset_n = 1'b0;
    #1;
    checkOutput("t5_addr_rst",  m_address, 0);
    checkOutput("t5_be_rst",    m_byteenable, 0);
    checkOutput("t5_rw_rst",    {m_read, m_write}, 0);
    checkOutput("t5_burst_rst", m_burstcount, 1);
    checkOutput("t5_d_rdata",   d_rdata, 0);
    checkOutput("t5_acks_rst",  {i_ack, d_ack}, 0);
    applyStimulus(1'b0, 28'h0, 1'b0, 1'b0, 28'h0, 32'h0, 4'h0);
    tick();
    checkOutput("t5_no_ack_in_rst", {i_ack, d_ack}, 0);
    tick();
    reset_reset_n = 1'b1;
    applyStimulus(1'b1, 28'h0000600, 1'b1, 1'b0, 28'h0000700, 32'h0, 4'hF);
    tick();
    checkOutput("t5_tie_addr", m_address, 28'h0000600);
    checkOutput("t5_tie_read", m_read, 1);
    runTxn(32'h600D0001, gi, gd);
    checkOutput("t5_owner_i", {gi, gd}, 2'b10);
    checkOutput("t5_i_rdata", i_rdata, 32'h600D0001);
    i_req = 1'b0;
    tick();
    runTxn(32'h600D0002, gi, gd);
    checkOutput("t5_owner_d", {gi, gd}, 2'b01);
    checkOutput("t5_d_rdata_done", d_rdata, 32'h600D0002);
    d_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
